// File: rtl/rf_access_sequencer_if.sv
// rf_access_sequencer_if: decode, register-file and completion signals of the sequencer
interface rf_access_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] read_address_1;
  logic [ADDR_W-1:0] read_address_2;
  logic [DATA_W-1:0] data_register_1;
  logic [DATA_W-1:0] data_register_2;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] data_write;
  logic              write_enable;
  logic              done_valid;
  logic              done_ready;
  logic [DATA_W-1:0] result;
  logic              illegal;
  modport master (
    input  instr_valid, instr, data_register_1, data_register_2, done_ready,
    output instr_ready, read_address_1, read_address_2, write_address, data_write,
           write_enable, done_valid, result, illegal
  );
  modport slave (
    output instr_valid, instr, data_register_1, data_register_2, done_ready,
    input  instr_ready, read_address_1, read_address_2, write_address, data_write,
           write_enable, done_valid, result, illegal
  );
endinterface

// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer: issues one R-type instruction through regfile read, ALU and write-back
module rf_access_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic reset,
  rf_access_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [31:0] instr_q;
  logic [DATA_W-1:0] op_a, op_b, res_q, alu;
  logic ill_q, legal;
  logic [5:0] op, funct;
  logic [ADDR_W-1:0] rs, rt, rd;
  assign op = instr_q[31:26];
  assign funct = instr_q[5:0];
  assign rs = ADDR_W'(instr_q[25:21]);
  assign rt = ADDR_W'(instr_q[20:16]);
  assign rd = ADDR_W'(instr_q[15:11]);
  assign legal = op == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                 funct == 6'h25 || funct == 6'h2A);
  assign alu = funct == 6'h20 ? op_a + op_b :
               funct == 6'h22 ? op_a - op_b :
               funct == 6'h24 ? op_a & op_b :
               funct == 6'h25 ? op_a | op_b :
               DATA_W'($signed(op_a) < $signed(op_b));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      instr_q <= '0;
      op_a <= '0;
      op_b <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state == READ) begin
        op_a <= bus.data_register_1;
        op_b <= bus.data_register_2;
      end
      if (state == EXEC) begin
        res_q <= legal ? alu : '0;
        ill_q <= !legal;
      end
    end
  end
  // rd==0 and illegal instructions both bypass WRITE so r0 and the regfile stay untouched
  always_comb begin
    state_n = state == IDLE  ? (bus.instr_valid ? READ : IDLE) :
              state == READ  ? EXEC :
              state == EXEC  ? (legal && rd != '0 ? WRITE : DONE) :
              state == WRITE ? DONE :
              bus.done_ready ? IDLE : DONE;
    bus.instr_ready = state == IDLE;
    bus.read_address_1 = state == IDLE ? '0 : rs;
    bus.read_address_2 = state == IDLE ? '0 : rt;
    bus.write_enable = state == WRITE;
    bus.write_address = state == WRITE ? rd : '0;
    bus.data_write = state == WRITE ? res_q : '0;
    bus.done_valid = state == DONE;
    bus.result = state == DONE ? res_q : '0;
    bus.illegal = state == DONE && ill_q;
  end
endmodule

// File: tb/tb_rf_access_sequencer.sv
// tb_rf_access_sequencer: directed and randomized checks against a behavioural ALU/regfile model
module tb_rf_access_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wipe = 1'b1;
  logic poke_en = 1'b0;
  logic [4:0] poke_a = '0;
  logic [31:0] poke_d = '0;
  logic [31:0] regs [32];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rf_access_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  rf_access_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  assign bus.data_register_1 = regs[bus.read_address_1];
  assign bus.data_register_2 = regs[bus.read_address_2];

  always @(posedge clk) begin
    if (wipe) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else begin
      if (bus.write_enable) regs[bus.write_address] <= bus.data_write;
      if (poke_en) regs[poke_a] <= poke_d;
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {op, rs, rt, rd, 5'b0, f};
  endfunction

  // {illegal, result} for an instruction given its two source operand values
  function automatic logic [32:0] ref_alu(input logic [31:0] ins, input logic [31:0] a, b);
    if (ins[31:26] != 6'h00) return {1'b1, 32'h0};
    case (ins[5:0])
      6'h20: return {1'b0, a + b};
      6'h22: return {1'b0, a - b};
      6'h24: return {1'b0, a & b};
      6'h25: return {1'b0, a | b};
      6'h2A: return {1'b0, 31'h0, $signed(a) < $signed(b)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Offers one instruction, then records what the DUT does cycle by cycle (n = cycles after the handshake edge)
  task automatic issue(input logic [31:0] ins, input int hold, input logic nxt_v, input logic [31:0] nxt,
                       output int we_at, output int we_cnt, output logic [4:0] wa, output logic [31:0] wd,
                       output int dv_at, output logic [31:0] res, output logic ill,
                       output logic clean, output logic ok);
    int n, held;
    we_at = -1; we_cnt = 0; wa = '0; wd = '0; dv_at = -1; res = '0; ill = 1'b0;
    clean = 1'b1; ok = 1'b0; held = 0;
    bus.instr = ins; bus.instr_valid = 1'b1; bus.done_ready = 1'b0;
    n = 0;
    while (!bus.instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.instr_ready) return;
    @(posedge clk); #1;
    bus.instr_valid = nxt_v;
    bus.instr = nxt_v ? nxt : $urandom;
    for (n = 1; n < 60 && !ok; n++) begin
      if (bus.write_enable) begin
        we_cnt++;
        if (we_at < 0) begin we_at = n; wa = bus.write_address; wd = bus.data_write; end
      end else if (bus.write_address != 0 || bus.data_write != 0) clean = 1'b0;
      if (bus.read_address_1 != ins[25:21] || bus.read_address_2 != ins[20:16] || bus.instr_ready) clean = 1'b0;
      if (bus.done_valid) begin
        if (dv_at < 0) begin dv_at = n; res = bus.result; ill = bus.illegal; end
        else if (bus.result !== res || bus.illegal !== ill) clean = 1'b0;
        if (held >= hold) bus.done_ready = 1'b1;
        held++;
      end
      @(posedge clk); #1;
      if (bus.done_ready) begin bus.done_ready = 1'b0; ok = 1'b1; end
    end
  endtask

  task automatic test_reset();
    logic we_seen;
    vecs++; if (bus.instr_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", bus.instr_ready); end
    vecs++; if (bus.done_valid !== 1'b0 || bus.write_enable !== 1'b0 || bus.illegal !== 1'b0) begin
      errs++; $display("FAIL rst_flags got dv=%b we=%b ill=%b want 0", bus.done_valid, bus.write_enable, bus.illegal); end
    vecs++; if (bus.result !== 32'h0 || bus.data_write !== 32'h0) begin
      errs++; $display("FAIL rst_data got res=%h wd=%h want 0", bus.result, bus.data_write); end
    vecs++; if (bus.read_address_1 !== 5'd0 || bus.read_address_2 !== 5'd0 || bus.write_address !== 5'd0) begin
      errs++; $display("FAIL rst_addr got %0d/%0d/%0d want 0", bus.read_address_1, bus.read_address_2, bus.write_address); end
    set_reg(5'd1, 32'd9);
    set_reg(5'd2, 32'd9);
    bus.instr = mk(6'h00, 5'd1, 5'd2, 5'd4, 6'h20); bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    we_seen = 1'b0;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; we_seen |= bus.write_enable; end
    reset = 1'b0;
    vecs++; if (bus.instr_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
      errs++; $display("FAIL rst_mid got ready=%b dv=%b want 1/0", bus.instr_ready, bus.done_valid); end
    repeat (4) begin @(posedge clk); #1; we_seen |= bus.write_enable; end
    vecs++; if (we_seen !== 1'b0 || regs[4] !== 32'h0) begin
      errs++; $display("FAIL rst_nowrite got we_seen=%b r4=%h want 0/0", we_seen, regs[4]); end
  endtask

  task automatic test_add();
    int we_at, we_cnt, dv_at; logic [4:0] wa; logic [31:0] wd, res; logic ill, clean, ok;
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    issue(mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h20), 0, 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL add_timeout got no completion want completion"); end
    vecs++; if (we_at != 3 || we_cnt != 1) begin errs++; $display("FAIL add_we got at=%0d cnt=%0d want 3/1", we_at, we_cnt); end
    vecs++; if (wa !== 5'd3 || wd !== 32'd12) begin errs++; $display("FAIL add_write got %0d<=%0d want 3<=12", wa, wd); end
    vecs++; if (dv_at != 4 || res !== 32'd12 || ill !== 1'b0) begin
      errs++; $display("FAIL add_done got at=%0d res=%0d ill=%b want 4/12/0", dv_at, res, ill); end
    vecs++; if (!clean || regs[3] !== 32'd12) begin errs++; $display("FAIL add_side got clean=%b r3=%0d want 1/12", clean, regs[3]); end
  endtask

  task automatic test_sub_slt();
    int we_at, we_cnt, dv_at; logic [4:0] wa; logic [31:0] wd, res; logic ill, clean, ok;
    set_reg(5'd1, 32'd0);
    set_reg(5'd2, 32'd1);
    issue(mk(6'h00, 5'd1, 5'd2, 5'd4, 6'h22), 0, 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok || res !== 32'hFFFF_FFFF || wd !== 32'hFFFF_FFFF || ill !== 1'b0) begin
      errs++; $display("FAIL sub_wrap got ok=%b res=%h wd=%h ill=%b want 1/ffffffff/ffffffff/0", ok, res, wd, ill); end
    set_reg(5'd1, 32'hFFFF_FFFF);
    issue(mk(6'h00, 5'd1, 5'd2, 5'd5, 6'h2A), 0, 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok || res !== 32'd1 || regs[5] !== 32'd1 || we_at != 3) begin
      errs++; $display("FAIL slt_signed got ok=%b res=%h r5=%h we_at=%0d want 1/1/1/3", ok, res, regs[5], we_at); end
  endtask

  task automatic test_rd_zero();
    int we_at, we_cnt, dv_at; logic [4:0] wa; logic [31:0] wd, res; logic ill, clean, ok;
    set_reg(5'd1, 32'd40);
    set_reg(5'd2, 32'd2);
    issue(mk(6'h00, 5'd1, 5'd2, 5'd0, 6'h20), 0, 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok || we_cnt != 0 || dv_at != 3) begin
      errs++; $display("FAIL rd0_skip got ok=%b we_cnt=%0d dv_at=%0d want 1/0/3", ok, we_cnt, dv_at); end
    vecs++; if (res !== 32'd42 || ill !== 1'b0 || regs[0] !== 32'h0) begin
      errs++; $display("FAIL rd0_result got res=%0d ill=%b r0=%h want 42/0/0", res, ill, regs[0]); end
  endtask

  task automatic test_illegal();
    int we_at, we_cnt, dv_at; logic [4:0] wa; logic [31:0] wd, res; logic ill, clean, ok;
    logic [31:0] old;
    old = regs[6];
    issue(mk(6'h00, 5'd1, 5'd2, 5'd6, 6'h3F), 0, 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok || ill !== 1'b1 || res !== 32'h0 || we_cnt != 0 || dv_at != 3) begin
      errs++; $display("FAIL ill_funct got ok=%b ill=%b res=%h we=%0d dv_at=%0d want 1/1/0/0/3", ok, ill, res, we_cnt, dv_at); end
    issue(mk(6'h08, 5'd1, 5'd2, 5'd6, 6'h20), 0, 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok || ill !== 1'b1 || res !== 32'h0 || we_cnt != 0 || regs[6] !== old) begin
      errs++; $display("FAIL ill_op got ok=%b ill=%b res=%h we=%0d r6=%h want 1/1/0/0/%h", ok, ill, res, we_cnt, regs[6], old); end
  endtask

  task automatic test_backpressure();
    int we_at, we_cnt, dv_at; logic [4:0] wa; logic [31:0] wd, res; logic ill, clean, ok;
    logic [31:0] b;
    set_reg(5'd5, 32'd100);
    set_reg(5'd6, 32'd23);
    b = mk(6'h00, 5'd5, 5'd6, 5'd7, 6'h22);
    issue(mk(6'h00, 5'd5, 5'd6, 5'd5, 6'h20), 10, 1'b1, b, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok || !clean) begin errs++; $display("FAIL bp_stable got ok=%b clean=%b want 1/1", ok, clean); end
    vecs++; if (res !== 32'd123 || regs[5] !== 32'd123 || dv_at != 4) begin
      errs++; $display("FAIL bp_rdrs got res=%0d r5=%0d dv_at=%0d want 123/123/4", res, regs[5], dv_at); end
    vecs++; if (bus.instr_ready !== 1'b1) begin errs++; $display("FAIL bp_release got ready=%b want 1", bus.instr_ready); end
    issue(b, 0, 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
    vecs++; if (!ok || res !== 32'd100 || regs[7] !== 32'd100) begin
      errs++; $display("FAIL bp_second got ok=%b res=%0d r7=%0d want 1/100/100", ok, res, regs[7]); end
  endtask

  task automatic test_random();
    int we_at, we_cnt, dv_at, k; logic [4:0] wa; logic [31:0] wd, res; logic ill, clean, ok;
    logic [31:0] ins, old; logic [32:0] m; logic wr;
    logic [4:0] rs, rt, rd; logic [5:0] f, op;
    logic [5:0] fl [5];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int r = 1; r < 32; r++)
      set_reg(5'(r), r % 5 == 0 ? 32'h8000_0000 + 32'(r) : r % 7 == 0 ? 32'hFFFF_FFFF : $urandom);
    for (int i = 0; i < 40; i++) begin
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      k = $urandom_range(0, 6);
      f = k < 5 ? fl[k] : 6'($urandom);
      op = $urandom_range(0, 9) == 0 ? 6'($urandom_range(1, 63)) : 6'h00;
      ins = mk(op, rs, rt, rd, f);
      m = ref_alu(ins, regs[rs], regs[rt]);
      wr = !m[32] && rd != 0;
      old = regs[rd];
      issue(ins, $urandom_range(0, 3), 1'b0, 32'h0, we_at, we_cnt, wa, wd, dv_at, res, ill, clean, ok);
      vecs++; if (!ok || !clean) begin errs++; $display("FAIL rnd%0d_proto got ok=%b clean=%b want 1/1", i, ok, clean); end
      vecs++; if (res !== m[31:0] || ill !== m[32]) begin
        errs++; $display("FAIL rnd%0d_result ins=%h got %h/%b want %h/%b", i, ins, res, ill, m[31:0], m[32]); end
      vecs++; if (we_cnt != (wr ? 1 : 0) || (wr && (we_at != 3 || wa !== rd || wd !== m[31:0]))) begin
        errs++; $display("FAIL rnd%0d_write got cnt=%0d at=%0d %0d<=%h want %0d/3 %0d<=%h", i, we_cnt, we_at, wa, wd, wr, rd, m[31:0]); end
      vecs++; if (dv_at != (wr ? 4 : 3) || regs[rd] !== (wr ? m[31:0] : old)) begin
        errs++; $display("FAIL rnd%0d_lat got dv_at=%0d r%0d=%h want %0d/%h", i, dv_at, rd, regs[rd], wr ? 4 : 3, wr ? m[31:0] : old); end
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instr = '0; bus.done_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wipe = 1'b0;
    test_reset();
    test_add();
    test_sub_slt();
    test_rd_zero();
    test_illegal();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
